// File: rtl/result_uart_tx_if.sv
// result_uart_tx_if
//   Bundles the capture handshake and status/serial outputs of result_uart_tx.
//   master : the controller side (drives a3_valid/a3, observes everything else)
//   slave  : the result_uart_tx side
//   Signals:
//     a3_valid    one-cycle capture pulse (output-layer done)
//     a3[9:0]     binarized output vector, digit d maps to a3[9-d]
//     tx          UART 8N1 serial line, idle high
//     tx_busy     high while a capture is being transmitted
//     digit[3:0]  decoded digit of the last capture, 4'hF if none set
//     digit_valid last capture had at least one bit set
//     ambiguous   last capture had more than one bit set
//     overrun     sticky, a capture pulse arrived while busy
interface result_uart_tx_if;
    logic       a3_valid;
    logic [9:0] a3;
    logic       tx;
    logic       tx_busy;
    logic [3:0] digit;
    logic       digit_valid;
    logic       ambiguous;
    logic       overrun;

    modport master (
        output a3_valid, a3,
        input  tx, tx_busy, digit, digit_valid, ambiguous, overrun
    );

    modport slave (
        input  a3_valid, a3,
        output tx, tx_busy, digit, digit_valid, ambiguous, overrun
    );
endinterface

// File: rtl/result_uart_tx.sv
// result_uart_tx
//   Captures the 10-bit binarized output vector on a3_valid, decodes the
//   predicted digit and sends it as one ASCII character on a UART 8N1 line.
//   Optional: define RESULT_CRLF_EN to follow each character with CR and LF
//   frames sent back-to-back under a single busy period.
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    result_uart_tx_if.slave (a3_valid/a3 in; tx, tx_busy, digit,
//            digit_valid, ambiguous, overrun out)
//   Parameters:
//     CLK_FREQ      system clock in Hz
//     BAUD          UART bit rate
//     CLKS_PER_BIT  cycles per bit (derived, must be >= 2)
module result_uart_tx #(
    parameter int CLK_FREQ     = 100000000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic             clk,
    input  logic             rst_n,
    result_uart_tx_if.slave  bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    logic [1:0]    r_state;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit;
    logic [7:0]    r_char;
    logic          r_tx;
    logic          r_busy;
    logic [3:0]    r_digit;
    logic          r_digit_valid;
    logic          r_ambiguous;
    logic          r_overrun;
`ifdef RESULT_CRLF_EN
    logic [1:0]    r_frame;
`endif

    logic [3:0]    w_dec_digit;
    logic          w_dec_valid;
    logic [3:0]    w_pop;
    logic [7:0]    w_dec_char;
    logic [7:0]    w_byte;
    logic [2:0]    w_bit_inc;
    logic          w_baud_term;

    // Ascending scan of a3: a3[k] is digit 9-k, so the last hit is the
    // lowest digit.
    always_comb begin
        w_dec_digit = 4'hF;
        w_dec_valid = 1'b0;
        w_pop       = '0;
        for (int unsigned k = 0; k < 10; k++) begin
            w_pop = w_pop + {3'b000, bus.a3[k]};
            if (bus.a3[k]) begin
                w_dec_digit = 4'(9 - k);
                w_dec_valid = 1'b1;
            end
        end
        w_dec_char = w_dec_valid ? (8'h30 + {4'h0, w_dec_digit}) : 8'h3F;
    end

`ifdef RESULT_CRLF_EN
    always_comb begin
        case (r_frame)
            2'd1:    w_byte = 8'h0D;
            2'd2:    w_byte = 8'h0A;
            default: w_byte = r_char;
        endcase
    end
`else
    assign w_byte = r_char;
`endif

    assign w_bit_inc   = r_bit + 3'd1;
    assign w_baud_term = (r_baud == BAUD_LAST);

    // tx is registered and loaded with the level of the state being entered,
    // so the line changes exactly on the bit boundary edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_baud        <= '0;
            r_bit         <= '0;
            r_char        <= 8'h3F;
            r_tx          <= 1'b1;
            r_busy        <= 1'b0;
            r_digit       <= 4'hF;
            r_digit_valid <= 1'b0;
            r_ambiguous   <= 1'b0;
            r_overrun     <= 1'b0;
`ifdef RESULT_CRLF_EN
            r_frame       <= '0;
`endif
        end else begin
            if (bus.a3_valid && r_busy) begin
                r_overrun <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (bus.a3_valid) begin
                        r_char        <= w_dec_char;
                        r_digit       <= w_dec_digit;
                        r_digit_valid <= w_dec_valid;
                        r_ambiguous   <= (w_pop > 4'd1);
                        r_state       <= ST_START;
                        r_busy        <= 1'b1;
                        r_baud        <= '0;
                        r_bit         <= '0;
                        r_tx          <= 1'b0;
`ifdef RESULT_CRLF_EN
                        r_frame       <= '0;
`endif
                    end
                end

                ST_START: begin
                    if (w_baud_term) begin
                        r_state <= ST_DATA;
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_tx    <= w_byte[0];
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end

                ST_DATA: begin
                    if (w_baud_term) begin
                        r_baud <= '0;
                        if (r_bit == 3'd7) begin
                            r_state <= ST_STOP;
                            r_bit   <= '0;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit <= w_bit_inc;
                            r_tx  <= w_byte[w_bit_inc];
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end

                ST_STOP: begin
                    if (w_baud_term) begin
                        r_baud <= '0;
`ifdef RESULT_CRLF_EN
                        if (r_frame != 2'd2) begin
                            r_frame <= r_frame + 2'd1;
                            r_state <= ST_START;
                            r_tx    <= 1'b0;
                        end else begin
                            r_frame <= '0;
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
`else
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
`endif
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    assign bus.tx          = r_tx;
    assign bus.tx_busy     = r_busy;
    assign bus.digit       = r_digit;
    assign bus.digit_valid = r_digit_valid;
    assign bus.ambiguous   = r_ambiguous;
    assign bus.overrun     = r_overrun;

endmodule

// File: tb/tb_result_uart_tx.sv
// tb_result_uart_tx
//   Self-checking bench for result_uart_tx at CLKS_PER_BIT=16. Expected line
//   levels come from a frame-level model: per byte, start 0, eight data bits
//   LSB first, stop 1, each held 16 cycles.
module tb_result_uart_tx;

    localparam int CPB   = 16;
    localparam int FRAME = 10 * CPB;
`ifdef RESULT_CRLF_EN
    localparam int NF = 3;
`else
    localparam int NF = 1;
`endif
    localparam int TOTAL = NF * FRAME;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    logic [3:0] exp_digit;
    logic       exp_dv;
    logic       exp_amb;
    logic       exp_ovr;

    result_uart_tx_if bus ();

    result_uart_tx #(.CLK_FREQ(16), .BAUD(1)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_char(input logic [9:0] v);
        for (int d = 0; d < 10; d++)
            if (v[9-d]) return 8'h30 + 8'(d);
        return 8'h3F;
    endfunction

    function automatic logic [3:0] ref_digit(input logic [9:0] v);
        for (int d = 0; d < 10; d++)
            if (v[9-d]) return 4'(d);
        return 4'hF;
    endfunction

    // Line level at cycle c of the busy period (c = 0 is the first start cycle).
    function automatic logic exp_tx(input int c, input logic [7:0] ch);
        int f;
        int b;
        logic [7:0] by;
        f = c / FRAME;
        b = (c % FRAME) / CPB;
        by = (f == 0) ? ch : ((f == 1) ? 8'h0D : 8'h0A);
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return by[b-1];
    endfunction

    // Called at posedge+1 of an idle cycle; pulses a3_valid for one cycle.
    task automatic capture(input logic [9:0] v);
        bus.a3       = v;
        bus.a3_valid = 1'b1;
        @(negedge clk);
        chk("busy_before_accept", {31'b0, bus.tx_busy}, 32'd0);
        chk("tx_idle_before_accept", {31'b0, bus.tx}, 32'd1);
        @(posedge clk);
        #1;
        bus.a3_valid = 1'b0;
        bus.a3       = 10'($urandom);
        exp_digit = ref_digit(v);
        exp_dv    = (exp_digit != 4'hF);
        exp_amb   = ($countones(v) > 1);
    endtask

    // Walks ncyc cycles of the busy period, optionally pulsing a3_valid at pa/pb.
    task automatic run_frame(input logic [7:0] ch, input int ncyc, input int pa, input int pb);
        for (int c = 0; c < ncyc; c++) begin
            if (c == pa || c == pb) begin
                bus.a3_valid = 1'b1;
                bus.a3       = 10'($urandom);
                exp_ovr      = 1'b1;
            end
            @(negedge clk);
            if (c == 0) begin
                chk("digit", {28'b0, bus.digit}, {28'b0, exp_digit});
                chk("digit_valid", {31'b0, bus.digit_valid}, {31'b0, exp_dv});
                chk("ambiguous", {31'b0, bus.ambiguous}, {31'b0, exp_amb});
                chk("overrun_start", {31'b0, bus.overrun}, {31'b0, exp_ovr});
            end
            chk($sformatf("tx_c%0d", c), {31'b0, bus.tx}, {31'b0, exp_tx(c, ch)});
            chk($sformatf("busy_c%0d", c), {31'b0, bus.tx_busy}, 32'd1);
            @(posedge clk);
            #1;
            bus.a3_valid = 1'b0;
            bus.a3       = 10'($urandom);
        end
    endtask

    task automatic idle_check();
        @(negedge clk);
        chk("busy_after_frame", {31'b0, bus.tx_busy}, 32'd0);
        chk("tx_after_frame", {31'b0, bus.tx}, 32'd1);
        chk("overrun_idle", {31'b0, bus.overrun}, {31'b0, exp_ovr});
        chk("digit_idle", {28'b0, bus.digit}, {28'b0, exp_digit});
        @(posedge clk);
        #1;
    endtask

    logic [9:0] dir_vals [5];
    logic [9:0] v;

    initial begin
        checks   = 0;
        failures = 0;
        exp_ovr  = 1'b0;
        exp_digit = 4'hF;
        exp_dv   = 1'b0;
        exp_amb  = 1'b0;
        rst_n        = 1'b0;
        bus.a3_valid = 1'b0;
        bus.a3       = '0;
        dir_vals = '{10'b1000000000, 10'b0000000001, 10'b0000000000,
                     10'b0010010000, 10'b0000100000};

        #22;
        chk("rst_tx", {31'b0, bus.tx}, 32'd1);
        chk("rst_busy", {31'b0, bus.tx_busy}, 32'd0);
        chk("rst_digit", {28'b0, bus.digit}, 32'hF);
        chk("rst_dv", {31'b0, bus.digit_valid}, 32'd0);
        chk("rst_amb", {31'b0, bus.ambiguous}, 32'd0);
        chk("rst_ovr", {31'b0, bus.overrun}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed patterns.
        for (int i = 0; i < 5; i++) begin
            capture(dir_vals[i]);
            run_frame(ref_char(dir_vals[i]), TOTAL, -1, -1);
            idle_check();
        end

        // Random vectors and random one-hot vectors.
        for (int i = 0; i < 6; i++) begin
            if (i[0]) v = 10'($urandom_range(0, 1023));
            else      v = 10'(1 << $urandom_range(0, 9));
            capture(v);
            run_frame(ref_char(v), TOTAL, -1, -1);
            idle_check();
        end

        // Pulses mid-frame and on the final stop cycle are ignored but set overrun;
        // a pulse on the first idle cycle is accepted.
        capture(10'b0100000000);
        run_frame(ref_char(10'b0100000000), TOTAL, 50, TOTAL - 1);
        chk("digit_unchanged", {28'b0, bus.digit}, 32'd1);
        chk("overrun_set", {31'b0, bus.overrun}, 32'd1);
        capture(10'b0000001000);
        run_frame(ref_char(10'b0000001000), TOTAL, -1, -1);
        idle_check();

        // Reset mid-frame.
        capture(10'b0001000000);
        run_frame(ref_char(10'b0001000000), 80, -1, -1);
        rst_n = 1'b0;
        #1;
        chk("midrst_tx", {31'b0, bus.tx}, 32'd1);
        chk("midrst_busy", {31'b0, bus.tx_busy}, 32'd0);
        chk("midrst_digit", {28'b0, bus.digit}, 32'hF);
        chk("midrst_ovr", {31'b0, bus.overrun}, 32'd0);
        exp_ovr   = 1'b0;
        exp_digit = 4'hF;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle_check();
        capture(10'b0000000100);
        run_frame(ref_char(10'b0000000100), TOTAL, -1, -1);
        idle_check();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/result_uart_tx.md
Name: result_uart_tx

Overview:
- Downstream consumer of the 10-bit binarized output-layer vector and its one-cycle done pulse.
- Captures the vector and decodes it to a predicted digit 0-9.
- Serialises the digit as an ASCII character on a UART 8N1 line for the host.
- Reports capture status back to the controller through a busy flag and a sticky overrun flag.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD, 115200, UART bit rate.
- CLKS_PER_BIT, CLK_FREQ/BAUD, cycles per bit period (derived; must be >= 2).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a3_valid  input  1  one-cycle capture pulse; driven by the output-layer done pulse.
- a3  input  10  binarized output vector; 1 = +1, 0 = -1; digit d maps to a3[9-d].
- tx  output  1  UART serial line, idle high.
- tx_busy  output  1  high while a capture is being transmitted.
- digit  output  4  decoded digit of the last capture; 4'hF if no bit is set.
- digit_valid  output  1  last capture had at least one bit set.
- ambiguous  output  1  last capture had more than one bit set.
- overrun  output  1  sticky; a3_valid arrived while tx_busy=1.

Behaviour:
- Reset values (asynchronous, all outputs): tx=1, tx_busy=0, digit=4'hF, digit_valid=0, ambiguous=0, overrun=0. FSM goes to IDLE, baud and bit counters go to 0.
- Capture:
  - a3_valid with tx_busy=0: register a3 in that cycle.
  - digit, digit_valid and ambiguous update on the next edge.
  - tx_busy rises on the next edge.
- Decode:
  - d = lowest index with a3[9-d]=1.
  - Character = 8'h30+d.
  - No bit set: digit=4'hF, digit_valid=0, character = 8'h3F ('?').
  - ambiguous = popcount(a3) > 1.
- FSM states: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: tx=1. On an accepted capture, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. Bit counter runs 0..7 and wraps to 0.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
- Baud counter: counts 0..CLKS_PER_BIT-1. It advances the bit on the terminal count and clears on every state entry.
- Timing:
  - First start-bit cycle is the cycle after the accepting edge.
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
  - tx_busy is high from the first start cycle through the last stop cycle.
  - tx_busy is low on the cycle after the last stop cycle.
- Handshake and overrun:
  - a3_valid while tx_busy=1 is ignored: no re-capture, digit outputs unchanged.
  - It sets overrun=1, which is cleared only by rst_n.
  - This includes a3_valid on the final stop cycle.
  - a3_valid on the first cycle tx_busy=0 is accepted.
- a3 is sampled only on an accepted a3_valid. Changes on a3 at any other time have no effect.
- Reset mid-frame: tx returns high immediately (asynchronous). The partial frame is abandoned and not resumed.

Optional Feature:
- Macro: RESULT_CRLF_EN.
- Defined:
  - Each capture sends three frames back-to-back: character, 8'h0D, 8'h0A.
  - STOP of frames 1 and 2 goes directly to START; a 2-bit frame index selects the byte.
  - Total busy time is 30*CLKS_PER_BIT cycles.
  - tx_busy stays high across all three frames.
- Undefined: single-frame behaviour as above; the frame index logic is absent.

Test Plan:
- Bench settings: CLK_FREQ=16, BAUD=1, so CLKS_PER_BIT=16.
- a3=10'b1000000000 pulsed -> digit=0, digit_valid=1, ambiguous=0. tx frame: 0,0,0,0,0,1,1,0,0,1 (start, 8'h30 LSB first, stop). Each bit 16 cycles, 160 cycles total. tx_busy low at cycle 161.
- a3=10'b0000000001 -> digit=9, character 8'h39. a3=10'b0000000000 -> digit=4'hF, digit_valid=0, character 8'h3F.
- a3=10'b0010010000 -> digit=2, ambiguous=1, character 8'h32.
- Second a3_valid 50 cycles into a frame, and another on the last stop cycle -> both ignored, digit unchanged, overrun=1. Pulse on the first idle cycle -> accepted, overrun stays 1.
- rst_n low at cycle 80 of a frame -> tx=1, tx_busy=0, digit=4'hF, overrun=0 immediately. Next capture transmits a clean frame.
- With RESULT_CRLF_EN defined, a3=10'b0000100000 -> bytes 8'h34, 8'h0D, 8'h0A are contiguous. tx_busy is high for 480 cycles.
